// File: rtl/mcu_subsys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_subsys_pkg
// Brief    : Shared types for the MCU subsystem two-master memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_subsys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TOUT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [1:0] c_GRANT_NONE = 2'b00;

  // Round-robin pick: 1 selects master 1. On contention the master that was
  // not served last wins.
  function automatic logic pick_master(input logic v0, input logic v1, input logic last);
    return v1 && (!v0 || !last);
  endfunction

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_subsys_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mcu_subsys_mem_arb
// Brief    : Two-master round-robin arbiter onto one native memory slave port,
//            with bounded-latency timeout and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_subsys_mem_arb
  import mcu_subsys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err_timeout,
  input  logic        err_clr
);

  // A width of at least 1 keeps the counter legal when the timeout is disabled.
  localparam int unsigned       c_CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic               c_TOUT_EN  = (TIMEOUT_CYCLES != 0);

  arb_state_t          r_state;
  logic                r_last;
  logic                r_owner;
  logic                r_err;
  logic [c_CNT_W-1:0]  r_cnt;

  mem_req_t w_m0_req;
  mem_req_t w_m1_req;
  mem_req_t w_own_req;
  logic     w_own_valid;
  logic     w_in_gnt;
  logic     w_tout_hit;
  logic     w_enter_tout;
  logic     w_pick;

  assign w_m0_req     = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_m1_req     = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign w_own_req    = r_owner ? w_m1_req : w_m0_req;
  assign w_own_valid  = r_owner ? m1_valid : m0_valid;
  assign w_in_gnt     = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_tout_hit   = c_TOUT_EN && (r_cnt == c_CNT_LAST);
  assign w_enter_tout = w_in_gnt && w_own_valid && !s_ready && w_tout_hit;
  assign w_pick       = pick_master(m0_valid, m1_valid, r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // Entering timeout overrides a simultaneous clear request.
      if (w_enter_tout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (m0_valid || m1_valid) begin
            r_owner <= w_pick;
            r_state <= w_pick ? ST_GNT1 : ST_GNT0;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (!w_own_valid) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (s_ready) begin
            r_state <= ST_IDLE;
            r_last  <= r_owner;
            r_cnt   <= '0;
          end else if (w_enter_tout) begin
            r_state <= ST_TOUT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_TOUT: begin
          r_state <= ST_IDLE;
          r_last  <= r_owner;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    grant    = c_GRANT_NONE;
    case (r_state)
      ST_GNT0, ST_GNT1: begin
        s_valid = 1'b1;
        s_addr  = w_own_req.addr;
        s_wdata = w_own_req.wdata;
        s_wstrb = w_own_req.wstrb;
        grant   = grant_onehot(r_owner);
        if (r_owner) begin
          m1_ready = s_ready;
          m1_rdata = s_rdata;
        end else begin
          m0_ready = s_ready;
          m0_rdata = s_rdata;
        end
      end
      ST_TOUT: begin
        grant = grant_onehot(r_owner);
        if (r_owner) begin
          m1_ready = 1'b1;
          m1_rdata = TIMEOUT_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = TIMEOUT_RDATA;
        end
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mcu_subsys_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_subsys_mem_arb
// Brief    : Scenario bench for mcu_subsys_mem_arb with a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_subsys_mem_arb;

  localparam logic [31:0] c_RD_KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic        mst;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        err_timeout;
  logic        err_clr = 1'b0;
  logic        use_model = 1'b0;
  logic [31:0] fixed_rdata = '0;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_got;

  // Slave model: either a fixed word or an address-derived word.
  assign s_rdata = use_model ? (s_addr ^ c_RD_KEY) : fixed_rdata;

  always #5 clk = ~clk;

  mcu_subsys_mem_arb #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  // Every completion strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (m0_ready || m1_ready) begin
      checks++;
      mon_got = m1_ready ? m1_rdata : m0_rdata;
      if (m0_ready && m1_ready) begin
        failures++;
        $display("FAIL sb_both_ready got m0=%0b m1=%0b exp one-hot", m0_ready, m1_ready);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ready got m0=%0b m1=%0b exp none", m0_ready, m1_ready);
      end else begin
        mon_e = sb.pop_front();
        if (m1_ready !== mon_e.mst || mon_got !== mon_e.rdata) begin
          failures++;
          $display("FAIL sb_completion got mst=%0b rdata=%h exp mst=%0b rdata=%h",
                   m1_ready, mon_got, mon_e.mst, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; err_clr = 1'b0; s_ready = 1'b0;
    cyc();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    smp();
    checks++;
    if ({s_valid, grant, m0_ready, m1_ready, err_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {s_valid, grant, m0_ready, m1_ready, err_timeout});
    end
    checks++;
    if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin
      failures++;
      $display("FAIL reset_sbus got=%h exp=0", {s_addr, s_wdata, s_wstrb});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata});
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    cyc();
    use_model = 1'b0; fixed_rdata = 32'h1234_5678; s_ready = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'b0000;
    sb.push_back('{mst: 1'b0, rdata: 32'h1234_5678});
    smp();
    checks++;
    if ({s_valid, grant} !== 3'b000) begin
      failures++;
      $display("FAIL single_arb_cycle got=%b exp=000", {s_valid, grant});
    end
    cyc();
    smp();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'h100 || grant !== 2'b01) begin
      failures++;
      $display("FAIL single_slave_req got v=%0b a=%h g=%b exp v=1 a=00000100 g=01", s_valid, s_addr, grant);
    end
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL single_m0_resp got r=%0b d=%h exp r=1 d=12345678", m0_ready, m0_rdata);
    end
    cyc();
    m0_valid = 1'b0;
    smp();
    checks++;
    if ({s_valid, grant} !== 3'b000) begin
      failures++;
      $display("FAIL single_back_idle got=%b exp=000", {s_valid, grant});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    cyc();
    use_model = 1'b1; s_ready = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h200;
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{mst: 1'b0, rdata: 32'h200 ^ c_RD_KEY});
      sb.push_back('{mst: 1'b1, rdata: 32'h300 ^ c_RD_KEY});
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      smp();
      exp_g = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
      checks++;
      if (grant !== exp_g) begin
        failures++;
        $display("FAIL contention_grant cycle=%0d got=%b exp=%b", i, grant, exp_g);
      end
    end
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_write_passthrough();
    cyc();
    use_model = 1'b1; s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h400; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    sb.push_back('{mst: 1'b1, rdata: 32'h400 ^ c_RD_KEY});
    smp();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) s_ready = 1'b1;
      smp();
      checks++;
      if (s_wstrb !== 4'b0011 || s_wdata !== 32'hAABB_CCDD) begin
        failures++;
        $display("FAIL write_fields cycle=%0d got strb=%b data=%h exp strb=0011 data=aabbccdd", i, s_wstrb, s_wdata);
      end
      checks++;
      if (grant !== 2'b10) begin
        failures++;
        $display("FAIL write_grant cycle=%0d got=%b exp=10", i, grant);
      end
      checks++;
      if ({m0_ready, m0_rdata} !== 33'h0) begin
        failures++;
        $display("FAIL write_m0_quiet cycle=%0d got r=%0b d=%h exp r=0 d=0", i, m0_ready, m0_rdata);
      end
    end
    cyc();
    m1_valid = 1'b0; m1_wstrb = 4'b0000; s_ready = 1'b0;
  endtask

  task automatic test_timeout();
    cyc();
    s_ready = 1'b0; use_model = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h500; m0_wstrb = 4'b0000;
    sb.push_back('{mst: 1'b0, rdata: 32'hDEAD_BEEF});
    smp();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) err_clr = 1'b1;
      smp();
      checks++;
      if (s_valid !== 1'b1 || grant !== 2'b01 || err_timeout !== 1'b0) begin
        failures++;
        $display("FAIL tout_wait cycle=%0d got v=%0b g=%b e=%0b exp v=1 g=01 e=0", i, s_valid, grant, err_timeout);
      end
    end
    cyc();
    err_clr = 1'b0;
    smp();
    checks++;
    if (s_valid !== 1'b0 || grant !== 2'b01) begin
      failures++;
      $display("FAIL tout_cycle got v=%0b g=%b exp v=0 g=01", s_valid, grant);
    end
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL tout_resp got r=%0b d=%h exp r=1 d=deadbeef", m0_ready, m0_rdata);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL tout_err_set_wins got=%0b exp=1", err_timeout);
    end
    cyc();
    m0_valid = 1'b0; err_clr = 1'b1;
    smp();
    checks++;
    if (err_timeout !== 1'b1 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL tout_err_sticky got e=%0b v=%0b exp e=1 v=0", err_timeout, s_valid);
    end
    cyc();
    err_clr = 1'b0;
    smp();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL tout_err_clr got=%0b exp=0", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    s_ready = 1'b0; m1_valid = 1'b1; m1_addr = 32'h600;
    smp();
    cyc();
    smp();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_gnt1 got=%b exp=10", grant);
    end
    cyc();
    rst = 1'b1; m0_valid = 1'b1; m0_addr = 32'h700;
    smp();
    cyc();
    rst = 1'b0; s_ready = 1'b1;
    sb.push_back('{mst: 1'b0, rdata: 32'h700 ^ c_RD_KEY});
    sb.push_back('{mst: 1'b1, rdata: 32'h600 ^ c_RD_KEY});
    smp();
    checks++;
    if (s_valid !== 1'b0 || grant !== 2'b00 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got v=%0b g=%b e=%0b exp v=0 g=00 e=0", s_valid, grant, err_timeout);
    end
    cyc();
    smp();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_m0_first got=%b exp=01", grant);
    end
    cyc();
    m0_valid = 1'b0;
    smp();
    cyc();
    smp();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_pending_m1 got=%b exp=10", grant);
    end
    cyc();
    m1_valid = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_abort();
    cyc();
    s_ready = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h800;
    m1_valid = 1'b1; m1_addr = 32'h900;
    sb.push_back('{mst: 1'b1, rdata: 32'h900 ^ c_RD_KEY});
    smp();
    cyc();
    smp();
    checks++;
    if (grant !== 2'b01 || m0_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_gnt0 got g=%b r=%0b exp g=01 r=0", grant, m0_ready);
    end
    cyc();
    m0_valid = 1'b0;
    smp();
    cyc();
    smp();
    checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got g=%b v=%0b r=%0b exp g=00 v=0 r=0", grant, s_valid, m0_ready);
    end
    cyc();
    s_ready = 1'b1;
    smp();
    checks++;
    if (grant !== 2'b10 || s_addr !== 32'h900) begin
      failures++;
      $display("FAIL abort_m1_served got g=%b a=%h exp g=10 a=00000900", grant, s_addr);
    end
    cyc();
    m1_valid = 1'b0; s_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_passthrough();
    test_timeout();
    test_reset_mid();
    test_abort();
    cyc();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
